// File: rtl/fifo_checker_if.sv
// fifo_checker_if: observed sync-FIFO stimulus and response signals
interface fifo_checker_if #(parameter int FIFO_WIDTH = 16);
  logic                  rst_n;
  logic                  wr_en;
  logic                  rd_en;
  logic [FIFO_WIDTH-1:0] data_in;
  logic [FIFO_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic                  almostfull;
  logic                  almostempty;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  modport master (output rst_n, wr_en, rd_en, data_in, data_out, full, empty,
                  almostfull, almostempty, wr_ack, overflow, underflow);
  modport slave (input rst_n, wr_en, rd_en, data_in, data_out, full, empty,
                 almostfull, almostempty, wr_ack, overflow, underflow);
endinterface

// File: rtl/fifo_checker.sv
// fifo_checker: passive golden-model observer that flags sync-FIFO misbehaviour
module fifo_checker #(
  parameter int FIFO_WIDTH  = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int CNT_W       = 16,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  fifo_checker_if.slave     mon,
  output logic              err_data,
  output logic              err_flag,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  pass_count,
  output logic              halted
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] AF_C   = (AW+1)'(FIFO_DEPTH - 1);
  typedef enum logic [1:0] {IDLE, CHECK, HALT} state_t;
  state_t                state_q, state_d;
  logic [AW:0]           cnt_q, cnt_d;
  logic [AW-1:0]         wp_q, wp_d, rp_q, rp_d;
  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [FIFO_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic                  exp_v_q, exp_v_d, exp_ack_q, exp_ack_d, exp_ovf_q, exp_ovf_d;
  logic                  exp_udf_q, exp_udf_d, exp_rd_q, exp_rd_d;
  logic [FIFO_WIDTH-1:0] exp_data_q, exp_data_d;
  logic                  err_data_q, err_data_d, err_flag_q, err_flag_d;
  logic [CNT_W-1:0]      err_cnt_q, err_cnt_d, pass_cnt_q, pass_cnt_d;
  logic                  full_c, empty_c, wr_acc, rd_acc, flag_mm, data_mm, data_chk;
  always_comb begin
    full_c   = cnt_q == FULL_C;
    empty_c  = cnt_q == '0;
    wr_acc   = mon.wr_en & ~full_c;
    rd_acc   = mon.rd_en & ~empty_c;
    data_chk = exp_v_q & exp_rd_q;
    data_mm  = data_chk & (mon.data_out != exp_data_q);
    // Registered status is only meaningful once a prior in-reset-free edge captured it
    flag_mm  = (mon.full != full_c) | (mon.empty != empty_c)
             | (mon.almostfull != (cnt_q == AF_C)) | (mon.almostempty != (cnt_q == 1))
             | (exp_v_q & ({mon.wr_ack, mon.overflow, mon.underflow}
                           != {exp_ack_q, exp_ovf_q, exp_udf_q}));
    state_d    = state_q;
    cnt_d      = cnt_q;
    wp_d       = wp_q;
    rp_d       = rp_q;
    mem_d      = mem_q;
    exp_v_d    = exp_v_q;
    exp_ack_d  = exp_ack_q;
    exp_ovf_d  = exp_ovf_q;
    exp_udf_d  = exp_udf_q;
    exp_rd_d   = exp_rd_q;
    exp_data_d = exp_data_q;
    err_data_d = 1'b0;
    err_flag_d = 1'b0;
    err_cnt_d  = err_cnt_q;
    pass_cnt_d = pass_cnt_q;
    if (state_q == IDLE) begin
      state_d = en ? CHECK : IDLE;
    end else if (state_q == CHECK) begin
      if (!mon.rst_n) begin
        cnt_d   = '0;
        wp_d    = '0;
        rp_d    = '0;
        exp_v_d = 1'b0;
      end else begin
        if (wr_acc) mem_d[wp_q] = mon.data_in;
        wp_d       = wr_acc ? wp_q + 1'b1 : wp_q;
        rp_d       = rd_acc ? rp_q + 1'b1 : rp_q;
        cnt_d      = cnt_q + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
        exp_v_d    = 1'b1;
        exp_ack_d  = wr_acc;
        exp_ovf_d  = mon.wr_en & full_c;
        exp_udf_d  = mon.rd_en & empty_c;
        exp_rd_d   = rd_acc;
        exp_data_d = rd_acc ? mem_q[rp_q] : exp_data_q;
        err_data_d = data_mm;
        err_flag_d = flag_mm;
        err_cnt_d  = (data_mm | flag_mm) ? err_cnt_q + CNT_W'(!(&err_cnt_q)) : err_cnt_q;
        pass_cnt_d = (data_chk & ~data_mm) ? pass_cnt_q + CNT_W'(!(&pass_cnt_q)) : pass_cnt_q;
        state_d    = (STOP_ON_ERR && (data_mm | flag_mm)) ? HALT : CHECK;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wp_q       <= '0;
      rp_q       <= '0;
      exp_v_q    <= 1'b0;
      exp_ack_q  <= 1'b0;
      exp_ovf_q  <= 1'b0;
      exp_udf_q  <= 1'b0;
      exp_rd_q   <= 1'b0;
      exp_data_q <= '0;
      err_data_q <= 1'b0;
      err_flag_q <= 1'b0;
      err_cnt_q  <= '0;
      pass_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      mem_q      <= mem_d;
      exp_v_q    <= exp_v_d;
      exp_ack_q  <= exp_ack_d;
      exp_ovf_q  <= exp_ovf_d;
      exp_udf_q  <= exp_udf_d;
      exp_rd_q   <= exp_rd_d;
      exp_data_q <= exp_data_d;
      err_data_q <= err_data_d;
      err_flag_q <= err_flag_d;
      err_cnt_q  <= err_cnt_d;
      pass_cnt_q <= pass_cnt_d;
    end
  end
  assign err_data   = err_data_q;
  assign err_flag   = err_flag_q;
  assign err_count  = err_cnt_q;
  assign pass_count = pass_cnt_q;
  assign halted     = state_q == HALT;
endmodule

// File: tb/tb_fifo_checker.sv
// tb_fifo_checker: drives a behavioural FIFO with fault injection past two checker instances
module tb_fifo_checker;
  localparam int W = 16, D = 8, CW = 16;
  logic clk = 1'b0, rst, en;
  always #5 clk = ~clk;
  fifo_checker_if #(.FIFO_WIDTH(W)) mon();
  logic err_data, err_flag, halted, h_err_data, h_err_flag, h_halted;
  logic [CW-1:0] err_count, pass_count, h_err_count, h_pass_count;
  fifo_checker #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .CNT_W(CW), .STOP_ON_ERR(1'b0)) u_dut (
    .clk(clk), .rst(rst), .en(en), .mon(mon), .err_data(err_data), .err_flag(err_flag),
    .err_count(err_count), .pass_count(pass_count), .halted(halted));
  fifo_checker #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .CNT_W(CW), .STOP_ON_ERR(1'b1)) u_halt (
    .clk(clk), .rst(rst), .en(en), .mon(mon), .err_data(h_err_data), .err_flag(h_err_flag),
    .err_count(h_err_count), .pass_count(h_pass_count), .halted(h_halted));
  int f_cnt = 0, f_wp = 0, f_rp = 0;
  logic [W-1:0] f_mem [D];
  logic [W-1:0] f_dout = '0, inj_data = '0;
  logic f_ack = 0, f_ovf = 0, f_udf = 0, inj_ovf = 0;
  assign mon.full        = f_cnt == D;
  assign mon.empty       = f_cnt == 0;
  assign mon.almostfull  = f_cnt == D - 1;
  assign mon.almostempty = f_cnt == 1;
  assign mon.wr_ack      = f_ack;
  assign mon.overflow    = f_ovf ^ inj_ovf;
  assign mon.underflow   = f_udf;
  assign mon.data_out    = f_dout ^ inj_data;
  always @(posedge clk) begin
    logic wa, ra;
    wa = mon.wr_en && f_cnt < D;
    ra = mon.rd_en && f_cnt > 0;
    if (!mon.rst_n) begin
      f_cnt <= 0; f_wp <= 0; f_rp <= 0; f_ack <= 0; f_ovf <= 0; f_udf <= 0;
    end else begin
      f_ack <= wa;
      f_ovf <= mon.wr_en && f_cnt == D;
      f_udf <= mon.rd_en && f_cnt == 0;
      if (wa) begin f_mem[f_wp] <= mon.data_in; f_wp <= (f_wp + 1) % D; end
      if (ra) begin f_dout <= f_mem[f_rp]; f_rp <= (f_rp + 1) % D; end
      f_cnt <= f_cnt + int'(wa) - int'(ra);
    end
  end
  int checks = 0, errors = 0;
  logic [1:0] exp_q [$];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic w, input logic r, input logic [W-1:0] d, input logic [1:0] e);
    logic [1:0] got;
    @(negedge clk);
    mon.wr_en = w; mon.rd_en = r; mon.data_in = d;
    exp_q.push_back(e);
    @(posedge clk); #1;
    got = exp_q.pop_front();
    chk("err_data/err_flag", {30'd0, err_data, err_flag}, {30'd0, got});
  endtask
  initial begin
    rst = 1; en = 0;
    mon.rst_n = 1; mon.wr_en = 0; mon.rd_en = 0; mon.data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst err_count", 32'(err_count), 0);
    chk("rst pass_count", 32'(pass_count), 0);
    chk("rst halted", 32'(halted), 0);
    chk("rst err_data", 32'(err_data), 0);
    chk("rst err_flag", 32'(err_flag), 0);
    @(negedge clk); rst = 0; en = 1;
    @(posedge clk); #1; en = 0;
    for (int i = 1; i <= 8; i++) step(1, 0, W'(i), 2'b00);
    chk("full after 8 writes", 32'(mon.full), 1);
    for (int i = 1; i <= 8; i++) step(0, 1, '0, 2'b00);
    step(0, 0, '0, 2'b00);
    chk("empty after 8 reads", 32'(mon.empty), 1);
    chk("pass after 8 reads", 32'(pass_count), 8);
    chk("err after 8 reads", 32'(err_count), 0);
    for (int i = 1; i <= 8; i++) step(1, 0, W'(16 + i), 2'b00);
    step(1, 0, 16'hDEAD, 2'b00);
    step(0, 0, '0, 2'b00);
    step(1, 0, 16'hBEEF, 2'b00);
    inj_ovf = 1;
    step(0, 0, '0, 2'b01);
    inj_ovf = 0;
    chk("err after ovf fault", 32'(err_count), 1);
    chk("halt on first error", 32'(h_halted), 1);
    step(1, 1, 16'h0099, 2'b00);
    step(0, 0, '0, 2'b00);
    chk("pass after full rd+wr", 32'(pass_count), 9);
    for (int i = 0; i < 7; i++) step(0, 1, '0, 2'b00);
    step(0, 0, '0, 2'b00);
    chk("pass after drain", 32'(pass_count), 16);
    step(1, 1, 16'h0055, 2'b00);
    step(0, 0, '0, 2'b00);
    chk("no data cmp on empty rd+wr", 32'(pass_count), 16);
    step(0, 1, '0, 2'b00);
    step(0, 0, '0, 2'b00);
    chk("pass after 0x55 read", 32'(pass_count), 17);
    step(1, 0, 16'hA5A5, 2'b00);
    step(0, 1, '0, 2'b00);
    inj_data = 16'h0001;
    step(0, 0, '0, 2'b10);
    inj_data = '0;
    step(0, 0, '0, 2'b00);
    chk("pass after data fault", 32'(pass_count), 17);
    chk("err after data fault", 32'(err_count), 2);
    for (int i = 0; i < 5; i++) step(1, 0, W'(16'h0100 + i), 2'b00);
    mon.rst_n = 0;
    step(0, 0, '0, 2'b00);
    mon.rst_n = 1;
    inj_ovf = 1;
    step(0, 0, '0, 2'b00);
    inj_ovf = 0;
    step(0, 0, '0, 2'b00);
    chk("empty after mon reset", 32'(mon.empty), 1);
    step(0, 1, '0, 2'b00);
    step(0, 0, '0, 2'b00);
    chk("err after mon reset", 32'(err_count), 2);
    chk("halt err_count frozen", 32'(h_err_count), 1);
    chk("halt still halted", 32'(h_halted), 1);
    chk("halt err_data quiet", 32'(h_err_data), 0);
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    chk("halted cleared by rst", 32'(h_halted), 0);
    chk("err_count cleared by rst", 32'(err_count), 0);
    rst = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
